// File: rtl/hp_combat_ctrl.sv
// rtl/hp_combat_ctrl.sv - clocked combat resolution: settle, sample roll, classify hit/miss, saturating HP damage
module hp_combat_ctrl #(
    parameter int HP_W       = 4,
    parameter int HP_INIT    = 9,
    parameter int HIT_THRESH = 7,
    parameter int DMG        = 1,
    parameter int SETTLE     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      rand_in,
    input  logic            attack_req,
    input  logic            new_game,
    output logic [HP_W-1:0] hp,
    output logic [3:0]      roll,
    output logic            hit,
    output logic            miss,
    output logic            ko,
    output logic            busy
);

    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [HP_W-1:0]  HP_RST   = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0]  DMG_V    = HP_W'(DMG);
    localparam logic [3:0]       THR      = 4'(HIT_THRESH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESOLVE,
        S_KO
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [HP_W-1:0]  hp_q, hp_n, hp_res, hp_after_hit;
    logic [3:0]       roll_q, roll_n;
    logic             hit_q, hit_n;
    logic             miss_q, miss_n;
    logic             ko_q, ko_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hp_q    <= HP_RST;
            roll_q  <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            ko_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            hp_q    <= hp_n;
            roll_q  <= roll_n;
            hit_q   <= hit_n;
            miss_q  <= miss_n;
            ko_q    <= ko_n;
        end
    end

    // Saturating subtract: a hit that would take HP below zero lands exactly on zero.
    assign hp_after_hit = (hp_q <= DMG_V) ? '0 : hp_q - DMG_V;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        hp_n    = hp_q;
        roll_n  = roll_q;
        hit_n   = hit_q;
        miss_n  = miss_q;
        ko_n    = ko_q;
        hp_res  = hp_q;

        if (new_game) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            hp_n    = HP_RST;
            roll_n  = '0;
            hit_n   = 1'b0;
            miss_n  = 1'b0;
            ko_n    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (attack_req) begin
                        state_n = S_SETTLE;
                        cnt_n   = CNT_LOAD;
                    end
                end
                S_SETTLE: begin
                    // Only the value present on the final settle cycle is kept.
                    if (cnt_q == '0) begin
                        roll_n  = rand_in;
                        state_n = S_RESOLVE;
                    end else begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end
                end
                S_RESOLVE: begin
                    if (roll_q > THR) begin
                        hit_n  = 1'b1;
                        miss_n = 1'b0;
                        hp_res = hp_after_hit;
                    end else begin
                        hit_n  = 1'b0;
                        miss_n = 1'b1;
                        hp_res = hp_q;
                    end
                    hp_n = hp_res;
                    if (hp_res == '0) begin
                        ko_n    = 1'b1;
                        state_n = S_KO;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_KO: begin
                    ko_n = 1'b1;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    assign hp   = hp_q;
    assign roll = roll_q;
    assign hit  = hit_q;
    assign miss = miss_q;
    assign ko   = ko_q;
    assign busy = (state_q == S_SETTLE) || (state_q == S_RESOLVE);

endmodule

// File: tb/tb_hp_combat_ctrl.sv
// tb/tb_hp_combat_ctrl.sv - directed table-driven bench for hp_combat_ctrl (DMG=1 and DMG=4 instances)
module tb_hp_combat_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] rand_in;
    logic [1:0] ar;
    logic       new_game;

    logic [3:0] hp0, roll0, hp1, roll1;
    logic       hit0, miss0, ko0, busy0;
    logic       hit1, miss1, ko1, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    hp_combat_ctrl dut0 (
        .clk(clk), .reset(reset), .rand_in(rand_in), .attack_req(ar[0]), .new_game(new_game),
        .hp(hp0), .roll(roll0), .hit(hit0), .miss(miss0), .ko(ko0), .busy(busy0)
    );

    hp_combat_ctrl #(.DMG(4)) dut1 (
        .clk(clk), .reset(reset), .rand_in(rand_in), .attack_req(ar[1]), .new_game(new_game),
        .hp(hp1), .roll(roll1), .hit(hit1), .miss(miss1), .ko(ko1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [3:0] hp;
        logic       hit;
        logic       miss;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic busy_of(input int t);
        return (t != 0) ? busy1 : busy0;
    endfunction

    task automatic check_out(input int t, input string tag, input logic [3:0] e_hp, input logic [3:0] e_roll,
                             input logic e_hit, input logic e_miss, input logic e_ko, input logic e_busy);
        if (t == 0) begin
            chk({tag, ".hp"}, 32'(hp0), 32'(e_hp));
            chk({tag, ".roll"}, 32'(roll0), 32'(e_roll));
            chk({tag, ".hit"}, 32'(hit0), 32'(e_hit));
            chk({tag, ".miss"}, 32'(miss0), 32'(e_miss));
            chk({tag, ".ko"}, 32'(ko0), 32'(e_ko));
            chk({tag, ".busy"}, 32'(busy0), 32'(e_busy));
        end else begin
            chk({tag, ".hp"}, 32'(hp1), 32'(e_hp));
            chk({tag, ".roll"}, 32'(roll1), 32'(e_roll));
            chk({tag, ".hit"}, 32'(hit1), 32'(e_hit));
            chk({tag, ".miss"}, 32'(miss1), 32'(e_miss));
            chk({tag, ".ko"}, 32'(ko1), 32'(e_ko));
            chk({tag, ".busy"}, 32'(busy1), 32'(e_busy));
        end
    endtask

    // Pulse attack_req, hold rs during settle, present rf on the sampling cycle;
    // optional re-pulses land in SETTLE (after E0) and RESOLVE (after E4).
    task automatic attack_seq(input int t, input logic [3:0] rs, input logic [3:0] rf,
                              input bit repulse, output int bcnt);
        bcnt = 0;
        @(negedge clk);
        ar[t]   = 1'b1;
        rand_in = rs;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (busy_of(t)) bcnt++;
            ar[t] = repulse && (k == 1 || k == 5);
            if (k == 4) rand_in = rf;
            else if (k == 5) rand_in = rs;
        end
        ar[t] = 1'b0;
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    initial begin
        int b;

        tbl[0] = '{r: 4'h7, hp: 4'd9, hit: 1'b0, miss: 1'b1};
        tbl[1] = '{r: 4'h8, hp: 4'd8, hit: 1'b1, miss: 1'b0};
        tbl[2] = '{r: 4'hF, hp: 4'd7, hit: 1'b1, miss: 1'b0};
        tbl[3] = '{r: 4'h0, hp: 4'd7, hit: 1'b0, miss: 1'b1};
        tbl[4] = '{r: 4'hC, hp: 4'd6, hit: 1'b1, miss: 1'b0};

        reset    = 1'b1;
        ar       = 2'b00;
        new_game = 1'b0;
        rand_in  = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_out(0, "reset0", 4'd9, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out(1, "reset1", 4'd9, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        attack_seq(0, 4'hF, 4'hF, 1'b0, b);
        chk("first_busy_cycles", 32'(b), 32'd5);
        check_out(0, "first_hit", 4'd8, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);

        pulse_new_game();
        for (int i = 0; i < 5; i++) begin
            attack_seq(0, tbl[i].r, tbl[i].r, 1'b0, b);
            chk($sformatf("tbl%0d.busy_cycles", i), 32'(b), 32'd5);
            check_out(0, $sformatf("tbl%0d", i), tbl[i].hp, tbl[i].r, tbl[i].hit, tbl[i].miss, 1'b0, 1'b0);
        end

        attack_seq(0, 4'h2, 4'hD, 1'b0, b);
        check_out(0, "noise_hit", 4'd5, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0);
        attack_seq(0, 4'hF, 4'h3, 1'b0, b);
        check_out(0, "noise_miss", 4'd5, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);

        attack_seq(0, 4'h9, 4'h9, 1'b1, b);
        chk("repulse_busy_cycles", 32'(b), 32'd5);
        check_out(0, "repulse", 4'd4, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check_out(0, "repulse_quiet", 4'd4, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0);

        attack_seq(0, 4'hA, 4'hA, 1'b0, b);
        chk("hp3", 32'(hp0), 32'd3);

        @(negedge clk);
        ar[0]   = 1'b1;
        rand_in = 4'hE;
        @(negedge clk);
        ar[0]    = 1'b0;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_out(0, "ng_settle", 4'd9, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check_out(0, "ng_idle", 4'd9, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            attack_seq(0, 4'hC, 4'hC, 1'b0, b);
            check_out(0, $sformatf("ko_seq%0d", i), 4'(8 - i), 4'hC, 1'b1, 1'b0, (i == 8), 1'b0);
        end

        attack_seq(0, 4'h3, 4'h3, 1'b0, b);
        chk("ko_busy_cycles", 32'(b), 32'd0);
        check_out(0, "ko_hold", 4'd0, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0);

        pulse_new_game();
        check_out(0, "ng_ko", 4'd9, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        attack_seq(0, 4'h9, 4'h9, 1'b0, b);
        chk("after_ko_busy_cycles", 32'(b), 32'd5);
        check_out(0, "after_ko", 4'd8, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0);

        attack_seq(1, 4'hF, 4'hF, 1'b0, b);
        check_out(1, "dmg4_a", 4'd5, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        attack_seq(1, 4'hB, 4'hB, 1'b0, b);
        check_out(1, "dmg4_b", 4'd1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0);
        attack_seq(1, 4'h8, 4'h8, 1'b0, b);
        check_out(1, "dmg4_c", 4'd0, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("dmg4_dut0_untouched", 32'(hp0), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
